// File: rtl/ex_operand_stage.sv
// ex_operand_stage: one-entry operand register in front of the ALU, with MEM/WB bypass and stall refresh.
// Ports: clk/rst (sync, active-high), flush; in_* decoded instruction with valid/ready handshake;
// fwd_mem_*/fwd_wb_* bypass sources; out_* ALU operands and control with valid/ready handshake.
// Build option: define EX_OPERAND_FORWARDING_EN to enable bypass and stall refresh. When it is
// undefined, the fwd_* ports are ignored.
module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_alu_ctrl,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_src1_pc,
  input  logic            in_src2_imm,
  input  logic [4:0]      in_rd_addr,
  input  logic            in_reg_write,
  input  logic            fwd_mem_en,
  input  logic [4:0]      fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_en,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_ctrl,
  output logic [XLEN-1:0] out_src1,
  output logic [XLEN-1:0] out_src2,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [4:0]      out_rd_addr,
  output logic            out_reg_write
);
  logic            valid;
  logic [3:0]      alu_ctrl;
  logic [4:0]      rs1_addr, rs2_addr, rd_addr;
  logic [XLEN-1:0] rs1_data, rs2_data, imm, pc;
  logic            src1_pc, src2_imm, reg_write;
  logic [XLEN-1:0] byp1, byp2;
  logic            accept, stall;
  assign in_ready = !valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign stall    = valid && !out_ready;
`ifdef EX_OPERAND_FORWARDING_EN
  // MEM is younger than WB, so it wins; x0 is hardwired and never bypassed.
  assign byp1 = (rs1_addr != 5'd0 && fwd_mem_en && fwd_mem_rd == rs1_addr) ? fwd_mem_data :
                (rs1_addr != 5'd0 && fwd_wb_en  && fwd_wb_rd  == rs1_addr) ? fwd_wb_data  : rs1_data;
  assign byp2 = (rs2_addr != 5'd0 && fwd_mem_en && fwd_mem_rd == rs2_addr) ? fwd_mem_data :
                (rs2_addr != 5'd0 && fwd_wb_en  && fwd_wb_rd  == rs2_addr) ? fwd_wb_data  : rs2_data;
`else
  logic unused_fwd;
  assign byp1 = rs1_data;
  assign byp2 = rs2_data;
  assign unused_fwd = ^{fwd_mem_en, fwd_mem_rd, fwd_mem_data, fwd_wb_en, fwd_wb_rd, fwd_wb_data};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      alu_ctrl  <= '0;
      rs1_addr  <= '0;
      rs2_addr  <= '0;
      rs1_data  <= '0;
      rs2_data  <= '0;
      imm       <= '0;
      pc        <= '0;
      src1_pc   <= 1'b0;
      src2_imm  <= 1'b0;
      rd_addr   <= '0;
      reg_write <= 1'b0;
    end else begin
      valid <= !flush && (accept || stall);
      if (accept && !flush) begin
        alu_ctrl  <= in_alu_ctrl;
        rs1_addr  <= in_rs1_addr;
        rs2_addr  <= in_rs2_addr;
        rs1_data  <= in_rs1_data;
        rs2_data  <= in_rs2_data;
        imm       <= in_imm;
        pc        <= in_pc;
        src1_pc   <= in_src1_pc;
        src2_imm  <= in_src2_imm;
        rd_addr   <= in_rd_addr;
        reg_write <= in_reg_write;
      end else if (stall) begin
        // Latch forwarded values so they survive the producer retiring mid-stall.
        rs1_data <= byp1;
        rs2_data <= byp2;
      end
    end
  end
  assign out_valid     = valid;
  assign out_alu_ctrl  = alu_ctrl;
  assign out_src1      = src1_pc ? pc : byp1;
  assign out_src2      = src2_imm ? imm : byp2;
  assign out_rs2_data  = byp2;
  assign out_rd_addr   = rd_addr;
  assign out_reg_write = valid && reg_write;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed table, corner sequences and random traffic against a reference model.
module tb_ex_operand_stage;
`ifdef EX_OPERAND_FORWARDING_EN
  localparam bit fwd_on = 1'b1;
`else
  localparam bit fwd_on = 1'b0;
`endif
  typedef struct packed {
    logic [3:0]  ctrl;
    logic [4:0]  rs1a, rs2a;
    logic [31:0] rs1d, rs2d, imm, pc;
    logic        s1pc, s2imm;
    logic [4:0]  rd;
    logic        rw;
  } instr_t;
  typedef struct {
    logic        iv, ordy;
    logic [3:0]  ctrl;
    logic [4:0]  rs1a, rs2a;
    logic [31:0] rs1d, rs2d, imm;
    logic        s2imm;
    logic        me;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] es1, es2;
  } vec_t;
  logic clk = 1'b0, rst, flush, in_valid, in_ready;
  logic [3:0] in_alu_ctrl, out_alu_ctrl;
  logic [4:0] in_rs1_addr, in_rs2_addr, in_rd_addr, fwd_mem_rd, fwd_wb_rd, out_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc, fwd_mem_data, fwd_wb_data;
  logic in_src1_pc, in_src2_imm, in_reg_write, fwd_mem_en, fwd_wb_en;
  logic out_valid, out_ready, out_reg_write;
  logic [31:0] out_src1, out_src2, out_rs2_data;
  int checks = 0, errors = 0;
  instr_t m_held = '0;
  bit m_full = 1'b0;
  vec_t tbl[12];
  always #5 clk = ~clk;
  ex_operand_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_ctrl(in_alu_ctrl), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
    .in_src1_pc(in_src1_pc), .in_src2_imm(in_src2_imm), .in_rd_addr(in_rd_addr),
    .in_reg_write(in_reg_write), .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd),
    .fwd_wb_data(fwd_wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctrl(out_alu_ctrl), .out_src1(out_src1), .out_src2(out_src2),
    .out_rs2_data(out_rs2_data), .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Value an operand register should read given the forwards currently on the bus.
  function automatic logic [31:0] byp(input logic [4:0] a, input logic [31:0] d);
    if (!fwd_on || a == 5'd0) return d;
    if (fwd_mem_en && fwd_mem_rd == a) return fwd_mem_data;
    if (fwd_wb_en && fwd_wb_rd == a) return fwd_wb_data;
    return d;
  endfunction
  function automatic instr_t cur_in();
    return '{ctrl: in_alu_ctrl, rs1a: in_rs1_addr, rs2a: in_rs2_addr, rs1d: in_rs1_data,
             rs2d: in_rs2_data, imm: in_imm, pc: in_pc, s1pc: in_src1_pc, s2imm: in_src2_imm,
             rd: in_rd_addr, rw: in_reg_write};
  endfunction
  task automatic drive(input instr_t i);
    in_alu_ctrl = i.ctrl; in_rs1_addr = i.rs1a; in_rs2_addr = i.rs2a;
    in_rs1_data = i.rs1d; in_rs2_data = i.rs2d; in_imm = i.imm; in_pc = i.pc;
    in_src1_pc = i.s1pc; in_src2_imm = i.s2imm; in_rd_addr = i.rd; in_reg_write = i.rw;
  endtask
  task automatic set_fwd(input logic me, input logic [4:0] mrd, input logic [31:0] md,
                         input logic we, input logic [4:0] wrd, input logic [31:0] wd);
    fwd_mem_en = me; fwd_mem_rd = mrd; fwd_mem_data = md;
    fwd_wb_en = we; fwd_wb_rd = wrd; fwd_wb_data = wd;
  endtask
  task automatic check_model();
    chk("in_ready", in_ready, !m_full || out_ready);
    chk("out_valid", out_valid, m_full);
    chk("out_reg_write", out_reg_write, m_full && m_held.rw);
    if (m_full) begin
      chk("alu_ctrl", out_alu_ctrl, m_held.ctrl);
      chk("src1", out_src1, m_held.s1pc ? m_held.pc : byp(m_held.rs1a, m_held.rs1d));
      chk("src2", out_src2, m_held.s2imm ? m_held.imm : byp(m_held.rs2a, m_held.rs2d));
      chk("rs2_data", out_rs2_data, byp(m_held.rs2a, m_held.rs2d));
      chk("rd_addr", out_rd_addr, m_held.rd);
    end
  endtask
  task automatic model_update();
    if (rst) begin
      m_full = 1'b0;
      m_held = '0;
    end else if (flush) m_full = 1'b0;
    else if (in_valid && (!m_full || out_ready)) begin
      m_held = cur_in();
      m_full = 1'b1;
    end else if (m_full && out_ready) m_full = 1'b0;
    else if (m_full) begin
      m_held.rs1d = byp(m_held.rs1a, m_held.rs1d);
      m_held.rs2d = byp(m_held.rs2a, m_held.rs2d);
    end
  endtask
  task automatic half_a();
    @(negedge clk);
    check_model();
  endtask
  task automatic half_b();
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic step();
    half_a();
    half_b();
  endtask
  initial begin
    instr_t ins;
    tbl[0]  = '{1'b1, 1'b1, 4'h0, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 4'h1, 5'd5, 5'd6, 32'd9, 32'd3, 32'hFFFFFFFF, 1'b1,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'd5, 32'd7};
    tbl[2]  = '{1'b1, 1'b1, 4'h2, 5'd3, 5'd7, 32'h11, 32'h0, 32'h0, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 32'd9, 32'hFFFFFFFF};
    tbl[3]  = '{1'b0, 1'b0, 4'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0,
                1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 1'b1, fwd_on ? 32'hAA : 32'h11, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 4'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0,
                1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 1'b1, fwd_on ? 32'hAA : 32'h11, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 4'h3, 5'd0, 5'd0, 32'h22, 32'h33, 32'h0, 1'b0,
                1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB, 1'b0, 32'h0, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 4'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0,
                1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB, 1'b1, 32'h22, 32'h33};
    tbl[7]  = '{1'b0, 1'b1, 4'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBB, 1'b1, 32'h22, 32'h33};
    tbl[8]  = '{1'b1, 1'b1, 4'h4, 5'd9, 5'd9, 32'd1, 32'd2, 32'h0, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 4'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hCC, 1'b1,
                fwd_on ? 32'hCC : 32'd1, fwd_on ? 32'hCC : 32'd2};
    tbl[10] = '{1'b0, 1'b1, 4'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0,
                1'b1, 5'd9, 32'hDD, 1'b1, 5'd9, 32'hCC, 1'b1,
                fwd_on ? 32'hDD : 32'd1, fwd_on ? 32'hDD : 32'd2};
    tbl[11] = '{1'b0, 1'b1, 4'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive('0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (2) begin
      @(posedge clk);
      model_update();
    end
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst out_valid", out_valid, 32'd0);
    chk("rst in_ready", in_ready, 32'd1);
    chk("rst src1", out_src1, 32'd0);
    chk("rst src2", out_src2, 32'd0);
    chk("rst rs2_data", out_rs2_data, 32'd0);
    chk("rst alu_ctrl", out_alu_ctrl, 32'd0);
    chk("rst rd_addr", out_rd_addr, 32'd0);
    chk("rst reg_write", out_reg_write, 32'd0);
    half_b();
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
      drive('{ctrl: tbl[i].ctrl, rs1a: tbl[i].rs1a, rs2a: tbl[i].rs2a, rs1d: tbl[i].rs1d,
              rs2d: tbl[i].rs2d, imm: tbl[i].imm, pc: 32'h100 + i, s1pc: 1'b0,
              s2imm: tbl[i].s2imm, rd: 5'(i), rw: 1'b1});
      set_fwd(tbl[i].me, tbl[i].mrd, tbl[i].md, tbl[i].we, tbl[i].wrd, tbl[i].wd);
      half_a();
      chk($sformatf("tbl%0d valid", i), out_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d src1", i), out_src1, tbl[i].es1);
        chk($sformatf("tbl%0d src2", i), out_src2, tbl[i].es2);
      end
      half_b();
    end
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    ins = '{ctrl: 4'h5, rs1a: 5'd0, rs2a: 5'd4, rs1d: 32'h0, rs2d: 32'd1, imm: 32'h0,
            pc: 32'h200, s1pc: 1'b0, s2imm: 1'b0, rd: 5'd8, rw: 1'b1};
    drive(ins); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    set_fwd(1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 32'h0);
    step();
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    half_a();
    chk("refresh src2", out_src2, fwd_on ? 32'h55 : 32'd1);
    chk("refresh rs2_data", out_rs2_data, fwd_on ? 32'h55 : 32'd1);
    half_b();
    out_ready = 1'b1;
    step();
    ins.rd = 5'd10; drive(ins); in_valid = 1'b1;
    step();
    ins.rd = 5'd11; drive(ins); flush = 1'b1;
    half_a();
    chk("flush in_ready", in_ready, 32'd1);
    half_b();
    flush = 1'b0; in_valid = 1'b0;
    half_a();
    chk("flush out_valid", out_valid, 32'd0);
    chk("flush reg_write", out_reg_write, 32'd0);
    half_b();
    ins = '{ctrl: 4'h6, rs1a: 5'd2, rs2a: 5'd2, rs1d: 32'd7, rs2d: 32'd7, imm: 32'h0,
            pc: 32'h300, s1pc: 1'b0, s2imm: 1'b0, rd: 5'd3, rw: 1'b1};
    drive(ins); in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    set_fwd(1'b1, 5'd2, 32'h77, 1'b0, 5'd0, 32'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    half_a();
    chk("rst stall out_valid", out_valid, 32'd0);
    chk("rst stall in_ready", in_ready, 32'd1);
    chk("rst stall src1", out_src1, 32'd0);
    chk("rst stall rs2_data", out_rs2_data, 32'd0);
    half_b();
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 15) == 0);
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      drive('{ctrl: 4'($urandom), rs1a: 5'($urandom_range(0, 3)), rs2a: 5'($urandom_range(0, 3)),
              rs1d: $urandom, rs2d: $urandom, imm: $urandom, pc: $urandom,
              s1pc: 1'($urandom), s2imm: 1'($urandom), rd: 5'($urandom), rw: 1'($urandom)});
      set_fwd(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
